// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto a single shared memory port (IDLE/BUSY/DONE).
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and the err_timeout flag.
module mem_port_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_oe,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [2*SIZE_W-1:0] req_size,
    output logic [2*DATA_W-1:0] req_rdata,
    output logic [1:0]          req_rdy,
    output logic                mem_oe,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [SIZE_W-1:0]   mem_size,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rdy,
    output logic                err_conflict
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                err_timeout
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_reg;
    logic              last_grant_reg;
    logic              grant_reg;
    logic              dir_we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [SIZE_W-1:0] size_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_conflict_reg;

    logic [1:0] valid;
    logic [1:0] conflict;
    logic       grant_any;
    logic       grant_next;

    always_comb begin
        valid      = req_oe ^ req_we;
        conflict   = req_oe & req_we;
        grant_any  = |valid;
        // On a tie the requester not served last wins; otherwise the lone valid one.
        grant_next = (valid == 2'b11) ? ~last_grant_reg : valid[1];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] busy_cnt_reg;
    logic             err_timeout_reg;
    assign err_timeout = err_timeout_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_grant_reg   <= 1'b1;
            grant_reg        <= 1'b0;
            dir_we_reg       <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            size_reg         <= '0;
            rdata_reg        <= '0;
            err_conflict_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            busy_cnt_reg     <= '0;
            err_timeout_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|conflict) err_conflict_reg <= 1'b1;
                    if (grant_any) begin
                        state_reg      <= BUSY;
                        last_grant_reg <= grant_next;
                        grant_reg      <= grant_next;
                        dir_we_reg     <= req_we[grant_next];
                        addr_reg       <= grant_next ? req_addr[2*ADDR_W-1:ADDR_W]
                                                     : req_addr[ADDR_W-1:0];
                        wdata_reg      <= grant_next ? req_wdata[2*DATA_W-1:DATA_W]
                                                     : req_wdata[DATA_W-1:0];
                        size_reg       <= grant_next ? req_size[2*SIZE_W-1:SIZE_W]
                                                     : req_size[SIZE_W-1:0];
`ifdef ARB_TIMEOUT_EN
                        busy_cnt_reg   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        state_reg <= DONE;
                        rdata_reg <= dir_we_reg ? '0 : mem_rdata;
`ifdef ARB_TIMEOUT_EN
                    end else if (busy_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg       <= DONE;
                        rdata_reg       <= '0;
                        err_timeout_reg <= 1'b1;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg + 1'b1;
`endif
                    end
                end
                // One cycle here keeps a still-held, already-served request from re-granting.
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_oe       = (state_reg == BUSY) && !dir_we_reg;
    assign mem_we       = (state_reg == BUSY) && dir_we_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;
    assign mem_size     = size_reg;
    assign err_conflict = err_conflict_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign req_rdy[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
            assign req_rdata[gi*DATA_W +: DATA_W] = req_rdy[gi] ? rdata_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_oe = '0, req_we = '0;
    logic [21:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [7:0]  req_size = '0;
    logic [15:0] req_rdata;
    logic [1:0]  req_rdy;
    logic        mem_oe, mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [3:0]  mem_size;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        err_conflict;
`ifdef ARB_TIMEOUT_EN
    logic        err_timeout;
`endif

    int passed = 0;
    int total  = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_rdata(req_rdata), .req_rdy(req_rdy),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .err_conflict(err_conflict)
`ifdef ARB_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  oe, we;
        logic [10:0] a0, a1;
        logic [7:0]  wd0, wd1;
        logic [3:0]  s0, s1;
        logic [7:0]  mrd;
        int          dly;
        logic        x_oe, x_we;
        logic [10:0] x_addr;
        logic [7:0]  x_wdata;
        logic [3:0]  x_size;
        logic [1:0]  x_rdy;
        logic [15:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b1;
        req_oe = '0; req_we = '0; mem_rdy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clock);
        req_oe = v.oe; req_we = v.we;
        req_addr = {v.a1, v.a0}; req_wdata = {v.wd1, v.wd0}; req_size = {v.s1, v.s0};
        @(negedge clock);
        chk($sformatf("v%0d mem_oe", idx), 32'(mem_oe), 32'(v.x_oe));
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.x_we));
        chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.x_addr));
        chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.x_wdata));
        chk($sformatf("v%0d mem_size", idx), 32'(mem_size), 32'(v.x_size));
        chk($sformatf("v%0d err_conflict", idx), 32'(err_conflict), 32'(v.x_err));
        for (int k = 0; k < v.dly; k++) begin
            @(negedge clock);
            chk($sformatf("v%0d hold_en", idx), 32'({mem_oe, mem_we}), 32'({v.x_oe, v.x_we}));
        end
        mem_rdy = 1'b1; mem_rdata = v.mrd;
        @(negedge clock);
        mem_rdy = 1'b0;
        chk($sformatf("v%0d req_rdy", idx), 32'(req_rdy), 32'(v.x_rdy));
        chk($sformatf("v%0d req_rdata", idx), 32'(req_rdata), 32'(v.x_rdata));
        req_oe = '0; req_we = '0;
        @(negedge clock);
        chk($sformatf("v%0d idle_rdy", idx), 32'(req_rdy), 32'd0);
    endtask

    initial begin
        //           oe     we     a0      a1      wd0    wd1    s0  s1  mrd    dly oe we addr    wdata  size rdy    rdata      err
        vecs[0] = '{2'b01, 2'b00, 11'h005, 11'h000, 8'h00, 8'h00, 8, 0, 8'hA5, 2, 1, 0, 11'h005, 8'h00, 8, 2'b01, 16'h00A5, 0};
        vecs[1] = '{2'b00, 2'b10, 11'h000, 11'h3FF, 8'h11, 8'h5C, 2, 8, 8'h77, 1, 0, 1, 11'h3FF, 8'h5C, 8, 2'b10, 16'h0000, 0};
        vecs[2] = '{2'b10, 2'b00, 11'h001, 11'h123, 8'h22, 8'h33, 1, 4, 8'h3C, 0, 1, 0, 11'h123, 8'h33, 4, 2'b10, 16'h3C00, 0};
        vecs[3] = '{2'b11, 2'b00, 11'h0AA, 11'h155, 8'h44, 8'h55, 8, 8, 8'h81, 0, 1, 0, 11'h0AA, 8'h44, 8, 2'b01, 16'h0081, 0};
        vecs[4] = '{2'b11, 2'b00, 11'h0AA, 11'h155, 8'h44, 8'h55, 8, 8, 8'hE7, 1, 1, 0, 11'h155, 8'h55, 8, 2'b10, 16'hE700, 0};
        vecs[5] = '{2'b01, 2'b10, 11'h200, 11'h300, 8'h66, 8'h99, 8, 2, 8'h4B, 0, 1, 0, 11'h200, 8'h66, 8, 2'b01, 16'h004B, 0};
        vecs[6] = '{2'b01, 2'b10, 11'h200, 11'h300, 8'h66, 8'h99, 8, 2, 8'h4B, 0, 0, 1, 11'h300, 8'h99, 2, 2'b10, 16'h0000, 0};
        vecs[7] = '{2'b10, 2'b11, 11'h7FE, 11'h001, 8'hC3, 8'h3C, 15, 1, 8'h12, 0, 0, 1, 11'h7FE, 8'hC3, 15, 2'b01, 16'h0000, 1};

        // Reset state
        #2;
        chk("rst mem_oe", 32'(mem_oe), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst req_rdy", 32'(req_rdy), 32'd0);
        chk("rst req_rdata", 32'(req_rdata), 32'd0);
        chk("rst err_conflict", 32'(err_conflict), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(i, vecs[i]);

        // Both requesters held continuously: grants alternate 0,1,0,1
        reset_dut();
        @(negedge clock);
        req_oe = 2'b11; req_we = 2'b00;
        req_addr = {11'h020, 11'h010};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("rr%0d mem_oe", i), 32'(mem_oe), 32'd1);
            chk($sformatf("rr%0d mem_addr", i), 32'(mem_addr), (i % 2 == 0) ? 32'h010 : 32'h020);
            mem_rdy = 1'b1; mem_rdata = 8'(8'h10 + i);
            @(negedge clock);
            mem_rdy = 1'b0;
            chk($sformatf("rr%0d req_rdy", i), 32'(req_rdy), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d req_rdata", i), 32'(req_rdata),
                (i % 2 == 0) ? 32'(8'h10 + i) : (32'(8'h10 + i) << 8));
            @(negedge clock);
            chk($sformatf("rr%0d stale_oe", i), 32'(mem_oe), 32'd0);
            chk($sformatf("rr%0d idle_rdy", i), 32'(req_rdy), 32'd0);
            if (i == 3) req_oe = 2'b00;
        end

        // Inputs changed during BUSY must not disturb the latched access; mem_rdy in IDLE ignored
        @(negedge clock);
        req_oe = 2'b01; req_addr = {11'h000, 11'h050};
        @(negedge clock);
        req_addr = {11'h000, 11'h7FF}; req_oe = 2'b00; req_we = 2'b01;
        @(negedge clock);
        chk("busy addr_held", 32'(mem_addr), 32'h050);
        chk("busy dir_held", 32'({mem_oe, mem_we}), 32'b10);
        mem_rdy = 1'b1; mem_rdata = 8'h5A;
        @(negedge clock);
        mem_rdy = 1'b0; req_we = 2'b00;
        chk("busy req_rdy", 32'(req_rdy), 32'd1);
        chk("busy req_rdata", 32'(req_rdata), 32'h005A);
        @(negedge clock);
        mem_rdy = 1'b1;
        @(negedge clock);
        mem_rdy = 1'b0;
        chk("idle_rdy_ignored rdy", 32'(req_rdy), 32'd0);
        chk("idle_rdy_ignored en", 32'({mem_oe, mem_we}), 32'd0);

        // Conflict on requester 0: no access, sticky flag until reset
        reset_dut();
        @(negedge clock);
        req_oe = 2'b01; req_we = 2'b01;
        @(negedge clock);
        chk("conf en", 32'({mem_oe, mem_we}), 32'd0);
        chk("conf err", 32'(err_conflict), 32'd1);
        req_oe = 2'b00; req_we = 2'b00;
        repeat (3) @(negedge clock);
        chk("conf sticky", 32'(err_conflict), 32'd1);
        chk("conf no_rdy", 32'(req_rdy), 32'd0);
        reset_dut();
        chk("conf cleared", 32'(err_conflict), 32'd0);

        // Asynchronous reset in BUSY aborts; late mem_rdy ignored; tie goes to requester 0 again
        @(negedge clock);
        req_oe = 2'b10; req_addr = {11'h0F0, 11'h000};
        @(negedge clock);
        chk("abort busy", 32'(mem_oe), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort async_oe", 32'(mem_oe), 32'd0);
        chk("abort async_addr", 32'(mem_addr), 32'd0);
        @(negedge clock);
        reset = 1'b0; req_oe = 2'b00; mem_rdy = 1'b1; mem_rdata = 8'hFF;
        @(negedge clock);
        mem_rdy = 1'b0;
        chk("abort no_rdy", 32'(req_rdy), 32'd0);
        chk("abort no_rdata", 32'(req_rdata), 32'd0);
        chk("abort idle_en", 32'({mem_oe, mem_we}), 32'd0);
        req_oe = 2'b11; req_addr = {11'h022, 11'h011};
        @(negedge clock);
        chk("abort tie_addr", 32'(mem_addr), 32'h011);
        req_oe = 2'b00; mem_rdy = 1'b1; mem_rdata = 8'h3E;
        @(negedge clock);
        mem_rdy = 1'b0;
        chk("abort tie_rdy", 32'(req_rdy), 32'd1);
        @(negedge clock);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no mem_rdy, DONE after 64 BUSY cycles
        req_oe = 2'b01; req_addr = {11'h000, 11'h0C0};
        @(negedge clock);
        req_oe = 2'b00;
        repeat (63) @(negedge clock);
        chk("to last_busy_oe", 32'(mem_oe), 32'd1);
        chk("to last_busy_rdy", 32'(req_rdy), 32'd0);
        chk("to err_early", 32'(err_timeout), 32'd0);
        @(negedge clock);
        chk("to req_rdy", 32'(req_rdy), 32'd1);
        chk("to req_rdata", 32'(req_rdata), 32'd0);
        chk("to err_timeout", 32'(err_timeout), 32'd1);
        chk("to mem_oe", 32'(mem_oe), 32'd0);
        @(negedge clock);
        chk("to idle_rdy", 32'(req_rdy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
